// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the instruction fetch unit
package ifu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_DISCARD = 3'd3,
        ST_HALT    = 3'd4
    } ifu_state_e;

    localparam logic [63:0] IFU_RESET_PC = 64'h8000_0000;

endpackage

// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - fetch-side memory read port (request + response channels)
interface ifu_fetch_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;
    logic              mem_resp_err;

    modport master (
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err
    );

    modport slave (
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err
    );

endinterface

// File: rtl/ifu_fifo.sv
// rtl/ifu_fifo.sv - instruction buffer: synchronous FIFO with flush and registered head
module ifu_fifo #(
    parameter int WIDTH = 97,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic                   head_valid_o,
    output logic [WIDTH-1:0]       head_data_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, wr_q;
    logic [PTR_W:0]   cnt_q;
    logic             do_push, do_pop;

    assign do_push = push_i && !flush_i && (cnt_q != FULL);
    assign do_pop  = pop_i && !flush_i && (cnt_q != '0);

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
        end
    end

    // Storage is cleared on reset so the head reads as all-zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    assign head_valid_o = (cnt_q != '0);
    assign head_data_o  = mem_q[rd_q];
    assign count_o      = cnt_q;

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - prefetching fetch unit: PC, request FSM, lane select, instruction buffer
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter int                DATA_W   = 64,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFU_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    ifu_fetch_if.master        mem,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_err,
    output logic               busy
);

    localparam int                IB         = $clog2(INSTR_W / 8);
    localparam int                DB         = $clog2(DATA_W / 8);
    localparam int                ENT_W      = INSTR_W + ADDR_W + 1;
    localparam int                CW         = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]     FULL       = CW'(DEPTH);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(DATA_W / 8 - 1);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(INSTR_W / 8);

    ifu_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] slice;
    logic [CW-1:0]      count, count_after;
    logic [ENT_W-1:0]   head;
    logic               req_fire, push, pop, pop_eff, in_flight;

    generate
        if (DATA_W == INSTR_W) begin : g_one_lane
            assign slice = mem.mem_resp_data[INSTR_W-1:0];
        end else begin : g_lanes
            logic [DB-IB-1:0] lane;
            assign lane  = pc_q[DB-1:IB];
            assign slice = mem.mem_resp_data[lane*INSTR_W +: INSTR_W];
        end
    endgenerate

    assign req_fire    = (state_q == ST_REQ) && mem.mem_req_ready;
    assign push        = (state_q == ST_WAIT) && mem.mem_resp_valid && !redirect_valid;
    assign pop         = instr_ready && !redirect_valid;
    assign pop_eff     = pop && instr_valid;
    assign count_after = count + CW'(push) - CW'(pop_eff);

    // A response still owed by memory after this edge must be swallowed first.
    assign in_flight = req_fire ||
                       (((state_q == ST_WAIT) || (state_q == ST_DISCARD)) && !mem.mem_resp_valid);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect_valid) begin
            pc_d    = {redirect_pc[ADDR_W-1:2], 2'b00};
            state_d = in_flight ? ST_DISCARD : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    if (count != FULL) state_d = ST_REQ;
                ST_REQ:     if (mem.mem_req_ready) state_d = ST_WAIT;
                ST_WAIT: begin
                    if (mem.mem_resp_valid) begin
                        pc_d = pc_q + PC_STEP;
                        if (mem.mem_resp_err)       state_d = ST_HALT;
                        else if (count_after != FULL) state_d = ST_REQ;
                        else                        state_d = ST_IDLE;
                    end
                end
                ST_DISCARD: if (mem.mem_resp_valid) state_d = ST_IDLE;
                ST_HALT:    state_d = ST_HALT;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    ifu_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (redirect_valid),
        .push_i       (push),
        .push_data_i  ({slice, pc_q, mem.mem_resp_err}),
        .pop_i        (pop),
        .head_valid_o (instr_valid),
        .head_data_o  (head),
        .count_o      (count)
    );

    assign instr     = head[ENT_W-1 -: INSTR_W];
    assign instr_pc  = head[ADDR_W:1];
    assign instr_err = head[0];

    assign mem.mem_req_valid = (state_q == ST_REQ);
    assign mem.mem_req_addr  = pc_q & ALIGN_MASK;
    assign busy              = (state_q != ST_IDLE) || instr_valid;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - randomized bench for ifu_fetch against a queue-based fetch model
module tb_ifu_fetch;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
        logic        err;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        instr_valid, instr_ready = 1'b0, instr_err, busy;
    logic [31:0] instr;
    logic [63:0] instr_pc;

    logic        i32_valid, i32_err, i32_busy;
    logic [31:0] i32_instr;
    logic [63:0] i32_pc;

    ifu_fetch_if #(.ADDR_W(64), .DATA_W(64)) m ();
    ifu_fetch_if #(.ADDR_W(64), .DATA_W(32)) m32 ();

    ifu_fetch #(
        .ADDR_W(64), .DATA_W(64), .INSTR_W(32), .DEPTH(4), .RESET_PC(64'h8000_0000)
    ) u_dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem(m.master), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .instr_err(instr_err), .busy(busy)
    );

    ifu_fetch #(
        .ADDR_W(64), .DATA_W(32), .INSTR_W(32), .DEPTH(4), .RESET_PC(64'h8000_0000)
    ) u_dut32 (
        .clk(clk), .rst(rst), .redirect_valid(1'b0), .redirect_pc(64'h0),
        .mem(m32.master), .instr_valid(i32_valid), .instr_ready(1'b1),
        .instr(i32_instr), .instr_pc(i32_pc), .instr_err(i32_err), .busy(i32_busy)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;

    int rdy_pct = 100, memrdy_pct = 100, min_lat = 1, max_lat = 1, memrdy_hold0 = 0;
    bit err_en = 1'b0;
    logic [63:0] err_pc = '0;

    // Model: fetch PC, expected buffer contents, the one outstanding request.
    logic [63:0] exp_pc;
    ent_t        exp_q[$];
    ent_t        pop_log[$];
    bit          pend = 1'b0, pend_drop = 1'b0, halted = 1'b0;
    int          pend_dly = 0, req_count = 0;
    logic [63:0] pend_pc = '0, last_acc_addr = '0;

    function automatic logic [31:0] instr_at(input logic [63:0] pc);
        if (pc == 64'h8000_0000) return 32'h0010_0093;
        if (pc == 64'h8000_0004) return 32'h0000_0013;
        return (pc[31:0] * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit safe_to_redirect();
        return !pend_drop && !(pend && pend_dly <= 1);
    endfunction

    task automatic step(input bit redir, input logic [63:0] rpc);
        bit          resp_now, acc, pop;
        logic [63:0] a;
        ent_t        e;
        instr_ready = ($urandom_range(0, 99) < rdy_pct);
        if (memrdy_hold0 > 0) begin
            m.mem_req_ready = 1'b0;
            memrdy_hold0--;
        end else begin
            m.mem_req_ready = ($urandom_range(0, 99) < memrdy_pct);
        end
        resp_now = 1'b0;
        m.mem_resp_valid = 1'b0;
        m.mem_resp_err   = 1'b0;
        m.mem_resp_data  = {$urandom, $urandom};
        if (pend) begin
            if (pend_dly <= 1) begin
                resp_now = 1'b1;
                a = pend_pc & ~64'h7;
                m.mem_resp_valid = 1'b1;
                m.mem_resp_data  = {instr_at(a + 64'd4), instr_at(a)};
                m.mem_resp_err   = err_en && (pend_pc == err_pc);
            end else begin
                pend_dly--;
            end
        end
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
        acc = m.mem_req_valid && m.mem_req_ready;
        pop = instr_valid && instr_ready && !redir;
        if (halted) begin
            vectors++;
            if (m.mem_req_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL halt_no_req: mem_req_valid=%b required 0", m.mem_req_valid);
            end
        end
        if (acc) begin
            vectors++;
            if (m.mem_req_addr !== (exp_pc & ~64'h7) || pend) begin
                miscompares++;
                $display("FAIL req_addr: addr=%h required %h outstanding=%0d",
                         m.mem_req_addr, exp_pc & ~64'h7, pend);
            end
            last_acc_addr = m.mem_req_addr;
            req_count++;
        end
        if (pop) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL pop_empty: got instr=%h pc=%h, model buffer empty", instr, instr_pc);
            end else begin
                e = exp_q.pop_front();
                if ({instr, instr_pc, instr_err} !== e) begin
                    miscompares++;
                    $display("FAIL pop_entry: got %h/%h/%b required %h/%h/%b",
                             instr, instr_pc, instr_err, e.instr, e.pc, e.err);
                end
            end
            pop_log.push_back({instr, instr_pc, instr_err});
        end
        if (resp_now) begin
            pend = 1'b0;
            if (!pend_drop && !redir) begin
                exp_q.push_back({instr_at(pend_pc), pend_pc, m.mem_resp_err});
                exp_pc += 64'd4;
                if (m.mem_resp_err) halted = 1'b1;
            end
            pend_drop = 1'b0;
        end
        if (acc) begin
            pend      = 1'b1;
            pend_dly  = $urandom_range(max_lat, min_lat);
            pend_pc   = exp_pc;
            pend_drop = 1'b0;
        end
        if (redir) begin
            exp_q.delete();
            exp_pc    = {rpc[63:2], 2'b00};
            halted    = 1'b0;
            pend_drop = pend;
        end
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        vectors++;
        if (instr_valid !== (exp_q.size() != 0) || exp_q.size() > 4) begin
            miscompares++;
            $display("FAIL instr_valid: got %b required %b (model depth %0d)",
                     instr_valid, exp_q.size() != 0, exp_q.size());
        end
    endtask

    task automatic do_redirect(input logic [63:0] pc);
        int n = 0;
        while (!safe_to_redirect() && n < 20) begin
            step(1'b0, 64'h0);
            n++;
        end
        vectors++;
        if (!safe_to_redirect()) begin
            miscompares++;
            $display("FAIL redirect_window: response never arrived within %0d cycles", n);
        end
        step(1'b1, pc);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (m.mem_req_valid !== 1'b0 || m.mem_req_addr !== 64'h8000_0000 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_bus: req_valid=%b addr=%h busy=%b required 0/80000000/0",
                     m.mem_req_valid, m.mem_req_addr, busy);
        end
        vectors++;
        if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 64'h0 || instr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_head: valid=%b instr=%h pc=%h err=%b required all 0",
                     instr_valid, instr, instr_pc, instr_err);
        end
        rst = 1'b0;
        vectors++;
        if (m.mem_req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: req_valid=%b required 0", m.mem_req_valid);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (m.mem_req_valid !== 1'b1 || m.mem_req_addr !== 64'h8000_0000) begin
            miscompares++;
            $display("FAIL first_req: req_valid=%b addr=%h required 1/80000000",
                     m.mem_req_valid, m.mem_req_addr);
        end
        exp_pc = 64'h8000_0000;
        exp_q.delete();
        pend = 1'b0; pend_drop = 1'b0; halted = 1'b0;
    endtask

    task automatic test_basic();
        rdy_pct = 100; memrdy_pct = 100; min_lat = 1; max_lat = 1;
        pop_log.delete();
        repeat (12) step(1'b0, 64'h0);
        vectors++;
        if (pop_log.size() < 2 || pop_log[0] !== {32'h0010_0093, 64'h8000_0000, 1'b0}
                               || pop_log[1] !== {32'h0000_0013, 64'h8000_0004, 1'b0}) begin
            miscompares++;
            $display("FAIL basic_first_two: got %0d pops, first=%h required 00100093@80000000 then 00000013@80000004",
                     pop_log.size(), pop_log.size() > 0 ? pop_log[0] : '0);
        end
    endtask

    task automatic test_backpressure();
        rdy_pct = 0; memrdy_pct = 100; min_lat = 1; max_lat = 1;
        do_redirect(64'h8000_1000);
        req_count = 0;
        repeat (30) step(1'b0, 64'h0);
        vectors++;
        if (req_count !== 4 || m.mem_req_valid !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL full_stop: requests=%0d req_valid=%b busy=%b required 4/0/1",
                     req_count, m.mem_req_valid, busy);
        end
        rdy_pct = 100;
        pop_log.delete();
        repeat (30) step(1'b0, 64'h0);
        vectors++;
        if (pop_log.size() < 8 || pop_log[0].pc !== 64'h8000_1000 || pop_log[3].pc !== 64'h8000_100C) begin
            miscompares++;
            $display("FAIL resume_order: pops=%0d first_pc=%h required >=8 starting 80001000",
                     pop_log.size(), pop_log.size() > 0 ? pop_log[0].pc : 64'h0);
        end
    endtask

    task automatic test_redirect_wait();
        int n = 0;
        rdy_pct = 100; memrdy_pct = 100; min_lat = 3; max_lat = 3;
        while (!(pend && pend_dly > 1 && !pend_drop) && n < 20) begin
            step(1'b0, 64'h0);
            n++;
        end
        step(1'b1, 64'h8000_0102);
        vectors++;
        if (instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL redirect_flush: instr_valid=%b required 0", instr_valid);
        end
        req_count = 0;
        n = 0;
        while (req_count == 0 && n < 20) begin
            step(1'b0, 64'h0);
            n++;
        end
        vectors++;
        if (req_count == 0 || last_acc_addr !== 64'h8000_0100) begin
            miscompares++;
            $display("FAIL redirect_addr: requests=%0d addr=%h required 80000100",
                     req_count, last_acc_addr);
        end
        pop_log.delete();
        repeat (20) step(1'b0, 64'h0);
        vectors++;
        if (pop_log.size() == 0 || pop_log[0].pc !== 64'h8000_0100) begin
            miscompares++;
            $display("FAIL redirect_stale: pops=%0d first_pc=%h required 80000100",
                     pop_log.size(), pop_log.size() > 0 ? pop_log[0].pc : 64'h0);
        end
        min_lat = 1;
    endtask

    task automatic test_bus_error();
        rdy_pct = 100; memrdy_pct = 100; min_lat = 1; max_lat = 2;
        err_en = 1'b1;
        err_pc = 64'h8000_0008;
        do_redirect(64'h8000_0000);
        pop_log.delete();
        repeat (30) step(1'b0, 64'h0);
        vectors++;
        if (pop_log.size() != 3 || pop_log[2] !== {instr_at(64'h8000_0008), 64'h8000_0008, 1'b1}) begin
            miscompares++;
            $display("FAIL bus_error_entry: pops=%0d last=%h required 3 ending err@80000008",
                     pop_log.size(), pop_log.size() > 0 ? pop_log[pop_log.size()-1] : '0);
        end
        vectors++;
        if (m.mem_req_valid !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL bus_error_halt: req_valid=%b busy=%b required 0/1", m.mem_req_valid, busy);
        end
        err_en = 1'b0;
    endtask

    task automatic test_req_stall();
        int n = 0;
        rdy_pct = 100; min_lat = 1; max_lat = 1;
        memrdy_hold0 = 1000;
        do_redirect(64'h8000_2000);
        while (!m.mem_req_valid && n < 10) begin
            step(1'b0, 64'h0);
            n++;
        end
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 64'h0);
            vectors++;
            if (m.mem_req_valid !== 1'b1 || m.mem_req_addr !== 64'h8000_2000) begin
                miscompares++;
                $display("FAIL req_stall: cycle %0d req_valid=%b addr=%h required 1/80002000",
                         c, m.mem_req_valid, m.mem_req_addr);
            end
        end
        memrdy_hold0 = 0;
        repeat (10) step(1'b0, 64'h0);
    endtask

    task automatic test_random();
        logic [63:0] tgt;
        for (int s = 0; s < 8; s++) begin
            rdy_pct    = $urandom_range(100, 10);
            memrdy_pct = $urandom_range(100, 20);
            min_lat    = 1;
            max_lat    = $urandom_range(4, 1);
            for (int c = 0; c < 60; c++) begin
                if (safe_to_redirect() && $urandom_range(0, 99) < 4) begin
                    tgt    = 64'h8000_0000 + 64'($urandom_range(0, 4095));
                    err_en = ($urandom_range(0, 3) == 0);
                    err_pc = {tgt[63:2], 2'b00} + 64'(4 * $urandom_range(0, 5));
                    step(1'b1, tgt);
                end else begin
                    step(1'b0, 64'h0);
                end
            end
        end
        err_en = 1'b0;
    endtask

    task automatic test_data_w32();
        logic [63:0] exp_a = 64'h8000_0000, exp_p = 64'h8000_0000, p_addr = '0;
        bit          p = 1'b0;
        int          n_acc = 0, n_pop = 0;
        for (int c = 0; c < 40; c++) begin
            m32.mem_req_ready  = 1'b1;
            m32.mem_resp_valid = p;
            m32.mem_resp_err   = 1'b0;
            m32.mem_resp_data  = instr_at(p_addr);
            #1;
            if (m32.mem_req_valid) begin
                vectors++;
                if (m32.mem_req_addr !== exp_a) begin
                    miscompares++;
                    $display("FAIL w32_addr: addr=%h required %h", m32.mem_req_addr, exp_a);
                end
                exp_a += 64'd4;
                n_acc++;
            end
            if (i32_valid) begin
                vectors++;
                if (i32_instr !== instr_at(exp_p) || i32_pc !== exp_p || i32_err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL w32_instr: got %h@%h required %h@%h",
                             i32_instr, i32_pc, instr_at(exp_p), exp_p);
                end
                exp_p += 64'd4;
                n_pop++;
            end
            p      = m32.mem_req_valid;
            p_addr = m32.mem_req_addr;
            @(posedge clk);
            #1;
        end
        m32.mem_req_ready  = 1'b0;
        m32.mem_resp_valid = 1'b0;
        vectors++;
        if (n_acc < 10 || n_pop < 10) begin
            miscompares++;
            $display("FAIL w32_progress: requests=%0d pops=%0d required >=10 each", n_acc, n_pop);
        end
    endtask

    initial begin
        m.mem_req_ready    = 1'b0;
        m.mem_resp_valid   = 1'b0;
        m.mem_resp_data    = '0;
        m.mem_resp_err     = 1'b0;
        m32.mem_req_ready  = 1'b0;
        m32.mem_resp_valid = 1'b0;
        m32.mem_resp_data  = '0;
        m32.mem_resp_err   = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect_wait();
        test_bus_error();
        test_req_stall();
        test_random();
        test_data_w32();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
